uart_rx_fifo: RTL

Receive-side byte buffer sitting directly downstream of the UART receiver top level. It captures each completed byte, with its error status, from the receiver's `valid`/`data` outputs and acknowledges it on `rdy` so the receiver never raises an overrun while buffer space remains. It holds bytes in a first-word-fall-through FIFO for the MAC/packet layer and keeps saturating error counters for frame, glitch and overflow events.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_rx_fifo_sat_counter.sv | 22 ++
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
package uart_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_LOW
    } rx_state_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-buffer byte link: level valid held until a one-cycle rdy, plus error flags.
// Master is the UART receiver, slave is the receive buffer.
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ferr;
    logic              rx_gerr;
    logic              rx_rdy;

    modport master (
        output rx_valid, rx_data, rx_ferr, rx_gerr,
        input  rx_rdy
    );

    modport slave (
        input  rx_valid, rx_data, rx_ferr, rx_gerr,
        output rx_rdy
    );
endinterface

// File: rtl/uart_rx_fifo_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: increment visible the cycle after the inc edge.
// Backpressure: none; holds at all-ones instead of wrapping, clr beats inc.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CW'(1);
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures receiver bytes into a FWFT FIFO and counts frame/glitch/overflow events.
// Latency: byte on dout/count one cycle after its sampling edge; rx_rdy pulses that same next cycle.
// Backpressure: receiver is always acknowledged; a full FIFO drops the new byte unless popped on the same edge.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_fifo_if.slave          rx,
    input  logic                   rd_en,
    output logic [BYTE_W-1:0]      dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [CW-1:0]          ferr_cnt,
    output logic [CW-1:0]          gerr_cnt,
    output logic [CW-1:0]          ovf_cnt,
    input  logic                   clr_cnt
);
    localparam int AW = $clog2(DEPTH);

    rx_state_t         state;
    logic              rdy_q;
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              capture;
    logic              push;
    logic              pop;
    logic              ferr_inc;
    logic              ovf_inc;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];
    assign rx.rx_rdy = rdy_q;

    // A full FIFO still accepts when the consumer pops on the same edge.
    assign capture  = (state == IDLE) && rx.rx_valid;
    assign pop      = rd_en && !empty;
    assign push     = capture && !rx.rx_ferr && (!full || rd_en);
    assign ferr_inc = capture && rx.rx_ferr;
    assign ovf_inc  = capture && !rx.rx_ferr && full && !rd_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx.rx_valid) begin
                        state <= ACK;
                        rdy_q <= 1'b1;
                    end
                end
                ACK: begin
                    state <= WAIT_LOW;
                    rdy_q <= 1'b0;
                end
                WAIT_LOW: begin
                    if (!rx.rx_valid) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx.rx_data;
    end

    sat_counter #(.CW(CW)) u_ferr_cnt (
        .clk (clk), .rst (rst), .clr (clr_cnt), .inc (ferr_inc), .q (ferr_cnt)
    );

    sat_counter #(.CW(CW)) u_gerr_cnt (
        .clk (clk), .rst (rst), .clr (clr_cnt), .inc (rx.rx_gerr), .q (gerr_cnt)
    );

    sat_counter #(.CW(CW)) u_ovf_cnt (
        .clk (clk), .rst (rst), .clr (clr_cnt), .inc (ovf_inc), .q (ovf_cnt)
    );
endmodule
